// File: rtl/round_banner_pkg.sv
// round_banner_pkg: shared types and constants for the round intro banner.
//   banner_state_t : sequencer states
//   ROUND_MAX      : largest round number that can be displayed (two BCD digits)
//   BCD_W          : width of one BCD digit
//   dd_adjust()    : double-dabble correction step (add 3 to any digit >= 5)
package round_banner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHOW,
        ST_BLINK,
        ST_DONE
    } banner_state_t;

    localparam int ROUND_MAX = 99;
    localparam int BCD_W     = 4;

    function automatic logic [2*BCD_W-1:0] dd_adjust(input logic [2*BCD_W-1:0] bcd);
        logic [BCD_W-1:0] hi;
        logic [BCD_W-1:0] lo;
        hi = bcd[2*BCD_W-1:BCD_W];
        lo = bcd[BCD_W-1:0];
        if (hi >= BCD_W'(5)) hi = hi + BCD_W'(3);
        if (lo >= BCD_W'(5)) lo = lo + BCD_W'(3);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: brings the asynchronous VGA vsync into the Clk domain and
// emits a one-cycle tick for every rising edge.
//   Clk       in  system clock
//   Reset     in  asynchronous, active-low reset
//   frame_clk in  vertical sync, asynchronous to Clk
//   tick      out one Clk cycle high per rising edge of frame_clk
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], frame_clk};
            prev_q <= sync_q[1];
        end
    end

    // Edge detect only on the fully synchronised bit.
    assign tick = sync_q[1] & ~prev_q;

endmodule

// File: rtl/round_banner_ctrl.sv
// round_banner_ctrl: sequences the "ROUND nn" intro banner. A round_start pulse
// freezes gameplay, converts the round number to two BCD digits, shows the banner
// solid, blinks the digits, then pulses banner_done and releases gameplay.
//   Clk         in  system clock
//   Reset       in  asynchronous, active-low reset
//   frame_clk   in  VGA vsync (asynchronous), paces the display phases
//   round_start in  one-cycle pulse, accepted only while idle
//   round_num   in  round number, saturated to 99 for display
//   skip        in  level; ends the banner early during SHOW/BLINK
//   banner_en   out ROUND glyphs visible
//   digits_en   out digit glyphs visible
//   tens/ones   out BCD digits of the displayed round
//   game_hold   out freeze gameplay
//   banner_done out one-cycle pulse at the end of the sequence
module round_banner_ctrl
    import round_banner_pkg::*;
#(
    parameter int SHOW_FRAMES   = 120,
    parameter int BLINK_FRAMES  = 8,
    parameter int BLINK_TOGGLES = 6,
    parameter int ROUND_W       = 7
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               round_start,
    input  logic [ROUND_W-1:0] round_num,
    input  logic               skip,
    output logic               banner_en,
    output logic               digits_en,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones,
    output logic               game_hold,
    output logic               banner_done
);

    localparam int IW = $clog2(ROUND_W + 1);
    localparam int SW = $clog2(SHOW_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);

    localparam logic [IW-1:0] ITER_LAST  = IW'(ROUND_W);
    localparam logic [SW-1:0] SHOW_LAST  = SW'(SHOW_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [TW-1:0] TOG_LAST   = TW'(BLINK_TOGGLES - 1);

    logic tick;

    frame_tick_gen u_frame_tick_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    banner_state_t        state_q, state_d;
    logic [ROUND_W-1:0]   shift_q, shift_d;
    logic [2*BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [IW-1:0]        iter_q, iter_d;
    logic [SW-1:0]        frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
    logic [TW-1:0]        tog_cnt_q, tog_cnt_d;
    logic [BCD_W-1:0]     tens_q, tens_d, ones_q, ones_d;
    logic                 banner_en_q, banner_en_d;
    logic                 digits_en_q, digits_en_d;
    logic                 game_hold_q, game_hold_d;
    logic                 banner_done_q, banner_done_d;

    assign bcd_adj = dd_adjust(bcd_q);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bcd_q         <= '0;
            iter_q        <= '0;
            frame_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            tog_cnt_q     <= '0;
            tens_q        <= '0;
            ones_q        <= '0;
            banner_en_q   <= 1'b0;
            digits_en_q   <= 1'b0;
            game_hold_q   <= 1'b0;
            banner_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bcd_q         <= bcd_d;
            iter_q        <= iter_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            tog_cnt_q     <= tog_cnt_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            banner_en_q   <= banner_en_d;
            digits_en_q   <= digits_en_d;
            game_hold_q   <= game_hold_d;
            banner_done_q <= banner_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        iter_d      = iter_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        tog_cnt_d   = tog_cnt_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        digits_en_d = digits_en_q;

        case (state_q)
            ST_IDLE: begin
                if (round_start) begin
                    state_d = ST_CONV;
                    shift_d = (32'(round_num) > ROUND_MAX) ? ROUND_W'(ROUND_MAX) : round_num;
                    bcd_d   = '0;
                    iter_d  = '0;
                end
            end
            ST_CONV: begin
                // ROUND_W shift iterations, then one cycle to publish the digits.
                if (iter_q == ITER_LAST) begin
                    tens_d      = bcd_q[2*BCD_W-1:BCD_W];
                    ones_d      = bcd_q[BCD_W-1:0];
                    frame_cnt_d = '0;
                    state_d     = ST_SHOW;
                end else begin
                    {bcd_d, shift_d} = {bcd_adj[2*BCD_W-2:0], shift_q, 1'b0};
                    iter_d           = iter_q + IW'(1);
                end
            end
            ST_SHOW: begin
                if (skip) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (frame_cnt_q == SHOW_LAST) begin
                        state_d     = ST_BLINK;
                        frame_cnt_d = '0;
                        blink_cnt_d = '0;
                        tog_cnt_d   = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + SW'(1);
                    end
                end
            end
            ST_BLINK: begin
                if (skip) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        digits_en_d = ~digits_en_q;
                        if (tog_cnt_q == TOG_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            tog_cnt_d = tog_cnt_q + TW'(1);
                        end
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        banner_en_d   = (state_d == ST_SHOW) || (state_d == ST_BLINK);
        game_hold_d   = banner_en_d || (state_d == ST_CONV);
        banner_done_d = (state_d == ST_DONE);
        if (state_d == ST_SHOW) begin
            digits_en_d = 1'b1;
        end else if (state_d != ST_BLINK) begin
            digits_en_d = 1'b0;
        end
    end

    assign banner_en   = banner_en_q;
    assign digits_en   = digits_en_q;
    assign tens        = tens_q;
    assign ones        = ones_q;
    assign game_hold   = game_hold_q;
    assign banner_done = banner_done_q;

endmodule

// File: tb/tb_round_banner_ctrl.sv
module tb_round_banner_ctrl;

    localparam int SHOW  = 4;
    localparam int BF    = 2;
    localparam int BT    = 4;
    localparam int RW    = 7;

    logic          Clk;
    logic          Reset;
    logic          frame_clk;
    logic          round_start;
    logic [RW-1:0] round_num;
    logic          skip;
    logic          banner_en;
    logic          digits_en;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic          game_hold;
    logic          banner_done;

    round_banner_ctrl #(
        .SHOW_FRAMES   (SHOW),
        .BLINK_FRAMES  (BF),
        .BLINK_TOGGLES (BT),
        .ROUND_W       (RW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .round_start (round_start),
        .round_num   (round_num),
        .skip        (skip),
        .banner_en   (banner_en),
        .digits_en   (digits_en),
        .tens        (tens),
        .ones        (ones),
        .game_hold   (game_hold),
        .banner_done (banner_done)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit fc_rand = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 idle, 1 converting, 2 banner on screen, 3 finished pulse
    int ph = 0;
    int conv_n = 0;
    int nticks = 0;
    int pend = 0;
    int m_tens = 0;
    int m_ones = 0;
    bit h1 = 0, h2 = 0, h3 = 0;
    bit tk;

    initial forever begin
        @(posedge Clk or negedge Reset);
        if (!Reset) begin
            ph = 0; conv_n = 0; nticks = 0; m_tens = 0; m_ones = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            // A rising vsync sampled two edges ago is seen as a tick now.
            tk = h2 && !h3;
            case (ph)
                0: if (round_start) begin
                    ph = 1;
                    conv_n = 0;
                    pend = (int'(round_num) > 99) ? 99 : int'(round_num);
                end
                1: begin
                    conv_n++;
                    if (conv_n == RW + 1) begin
                        ph = 2;
                        nticks = 0;
                        m_tens = pend / 10;
                        m_ones = pend % 10;
                    end
                end
                2: if (skip) ph = 3;
                   else if (tk) begin
                       nticks++;
                       if (nticks >= SHOW + BF * BT) ph = 3;
                   end
                default: ph = 0;
            endcase
            h3 = h2; h2 = h1; h1 = frame_clk;
        end
    end

    // compare process: every cycle, away from the active edge
    initial forever begin
        int e_dig;
        @(negedge Clk);
        if (ph == 2) e_dig = (nticks < SHOW) ? 1 : ((((nticks - SHOW) / BF) % 2) == 0 ? 1 : 0);
        else e_dig = 0;
        chk("model banner_en",   int'(banner_en),   (ph == 2) ? 1 : 0);
        chk("model digits_en",   int'(digits_en),   e_dig);
        chk("model game_hold",   int'(game_hold),   (ph == 1 || ph == 2) ? 1 : 0);
        chk("model banner_done", int'(banner_done), (ph == 3) ? 1 : 0);
        chk("model tens",        int'(tens),        m_tens);
        chk("model ones",        int'(ones),        m_ones);
    end

    initial forever begin
        @(negedge Clk);
        if (banner_done) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
            if (fc_rand && $urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
        end
    endtask

    task automatic tick_pulse();
        frame_clk = 1'b1;
        cyc(2);
        frame_clk = 1'b0;
        cyc(2);
    endtask

    task automatic start_round(input int num);
        round_num   = RW'(num);
        round_start = 1'b1;
        cyc(1);
        round_start = 1'b0;
    endtask

    task automatic finish_by_skip();
        skip = 1'b1;
        cyc(1);
        skip = 1'b0;
        cyc(2);
    endtask

    int exp_dig [12];
    int c3_num [4];
    int c3_t   [4];
    int c3_o   [4];

    initial begin
        int rise;
        int d0;
        exp_dig = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
        c3_num  = '{120, 0, 9, 127};
        c3_t    = '{9, 0, 0, 9};
        c3_o    = '{9, 0, 9, 9};

        Reset = 1'b1; frame_clk = 1'b0; round_start = 1'b0; round_num = '0; skip = 1'b0;
        #1 Reset = 1'b0;

        // 1: reset held with random inputs
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk); #1;
            frame_clk   = 1'($urandom);
            round_start = 1'($urandom);
            round_num   = RW'($urandom);
            skip        = 1'($urandom);
        end
        chk("reset banner_en", int'(banner_en), 0);
        chk("reset game_hold", int'(game_hold), 0);
        chk("reset tens", int'(tens), 0);
        frame_clk = 1'b0; round_start = 1'b0; skip = 1'b0;
        Reset = 1'b1;
        cyc(3);
        chk("post-reset idle game_hold", int'(game_hold), 0);

        // 2: round 37 full sequence
        start_round(37);
        chk("conv banner_en", int'(banner_en), 0);
        chk("conv game_hold", int'(game_hold), 1);
        rise = 0;
        for (int i = 1; i <= 20 && rise == 0; i++) begin
            cyc(1);
            if (banner_en) rise = i;
        end
        chk("banner_en latency", rise, 8);
        chk("r37 tens", int'(tens), 3);
        chk("r37 ones", int'(ones), 7);
        d0 = done_cnt;
        for (int t = 1; t <= 12; t++) begin
            tick_pulse();
            if (t < 12) begin
                chk("r37 digits_en after tick", int'(digits_en), exp_dig[t]);
                chk("r37 game_hold", int'(game_hold), 1);
            end
        end
        chk("r37 banner_done pulses", done_cnt - d0, 1);
        chk("r37 banner_en end", int'(banner_en), 0);
        chk("r37 game_hold end", int'(game_hold), 0);
        chk("r37 tens held", int'(tens), 3);

        // 3: saturation and small values
        for (int k = 0; k < 4; k++) begin
            start_round(c3_num[k]);
            cyc(10);
            chk("bcd tens", int'(tens), c3_t[k]);
            chk("bcd ones", int'(ones), c3_o[k]);
            finish_by_skip();
        end

        // 4: skip coinciding with tick 2 of SHOW
        start_round(45);
        cyc(10);
        tick_pulse();
        frame_clk = 1'b1;
        cyc(2);
        skip = 1'b1;
        cyc(1);
        chk("skip banner_done", int'(banner_done), 1);
        chk("skip banner_en", int'(banner_en), 0);
        chk("skip game_hold", int'(game_hold), 0);
        skip = 1'b0; frame_clk = 1'b0;
        cyc(3);

        // 5: ignored second start, reset during BLINK
        start_round(58);
        cyc(10);
        start_round(12);
        cyc(12);
        chk("ignored start tens", int'(tens), 5);
        chk("ignored start ones", int'(ones), 8);
        chk("ignored start banner_en", int'(banner_en), 1);
        repeat (6) tick_pulse();
        chk("blink digits off", int'(digits_en), 0);
        d0 = done_cnt;
        Reset = 1'b0;
        #1;
        chk("mid reset banner_en", int'(banner_en), 0);
        chk("mid reset game_hold", int'(game_hold), 0);
        chk("mid reset tens", int'(tens), 0);
        cyc(3);
        Reset = 1'b1;
        cyc(3);
        chk("mid reset no banner_done", done_cnt - d0, 0);

        // 6: no frame ticks, then a single one-cycle vsync pulse
        start_round(21);
        cyc(10);
        cyc(60);
        chk("stalled banner_en", int'(banner_en), 1);
        chk("stalled digits_en", int'(digits_en), 1);
        frame_clk = 1'b1;
        cyc(1);
        frame_clk = 1'b0;
        cyc(3);
        repeat (4) tick_pulse();
        chk("five ticks digits_en", int'(digits_en), 1);
        tick_pulse();
        chk("six ticks digits_en", int'(digits_en), 0);
        finish_by_skip();

        // random phase
        fc_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            round_start = ($urandom_range(0, 15) == 0);
            round_num   = RW'($urandom);
            skip        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 999) == 0) begin
                Reset = 1'b0;
                cyc(2);
                Reset = 1'b1;
            end
            cyc(1);
        end
        fc_rand = 0;
        round_start = 1'b0;
        skip = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
